// File: rtl/rf_pkg.sv
// Shared register-file definitions: write-enable encoding, geometry and the
// writeback entry carried through the write queue.
package rf_pkg;

  localparam logic [1:0] WEN_IDLE = 2'b00;
  localparam logic [1:0] WEN_ONE  = 2'b01;
  localparam logic [1:0] WEN_ZERO = 2'b10;
  localparam logic [1:0] WEN_DATA = 2'b11;

  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic [1:0]        kind;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_entry;

  // Constant-write kinds carry no payload; the register file supplies the value.
  function automatic wb_entry make_entry(input logic [1:0] kind,
                                         input logic [REG_AW-1:0] addr,
                                         input logic [XLEN-1:0] data);
    wb_entry e;
    e.kind = kind;
    e.addr = addr;
    e.data = (kind == WEN_DATA) ? data : '0;
    return e;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order writeback queue: two ordered pushes (a before b) and one pop per
// clock, with per-slot valid/address export for pending-write decode.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      flush,
  input  logic                      push_a,
  input  logic [$bits(wb_entry)-1:0] push_a_ent,
  input  logic                      push_b,
  input  logic [$bits(wb_entry)-1:0] push_b_ent,
  input  logic                      pop,
  output logic [$bits(wb_entry)-1:0] head_ent,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH*REG_AW-1:0]   ent_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry        mem_q [DEPTH];
  wb_entry        mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  b_idx;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    b_idx    = wr_ptr_q + PW'(push_a);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_a) mem_d[wr_ptr_q] = wb_entry'(push_a_ent);
      if (push_b) mem_d[b_idx]    = wb_entry'(push_b_ent);
      wr_ptr_d = wr_ptr_q + PW'(push_a) + PW'(push_b);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  // Payload storage needs no reset: slot validity comes from the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_ent = mem_q[rd_ptr_q];
  assign count    = count_q;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i]                = {1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q;
      ent_addr[i*REG_AW +: REG_AW] = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-side driver: arbitrates ALU and load writebacks into an
// in-order queue, drains one write per clock and publishes a pending-write mask.
module rf_wb_ctrl
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  flush,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [AW-1:0]         alu_addr,
  input  logic [DW-1:0]         alu_data,
  input  logic [1:0]            alu_kind,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DW-1:0]         ld_data,
  output logic [1:0]            WEn,
  output logic [AW-1:0]         AddrD,
  output logic [DW-1:0]         DataD,
  output logic [NUM_REGS-1:0]   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  wb_entry                 ld_ent, alu_ent, head_ent;
  wb_entry                 out_q, out_d;
  logic                    ld_push, alu_push, pop;
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH*REG_AW-1:0] ent_addr;

  // Readiness looks only at registered occupancy; the load owns the last slot.
  assign ld_ready  = !flush && (count < FULL_CNT);
  assign alu_ready = !flush && ((count < LAST_CNT) || ((count < FULL_CNT) && !ld_valid));

  assign ld_push  = ld_valid && ld_ready;
  assign alu_push = alu_valid && alu_ready && (alu_kind != WEN_IDLE);
  assign pop      = (count != '0) && !flush;

  assign ld_ent  = make_entry(WEN_DATA, REG_AW'(ld_addr), XLEN'(ld_data));
  assign alu_ent = make_entry(alu_kind, REG_AW'(alu_addr), XLEN'(alu_data));

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_       (rst_),
    .flush      (flush),
    .push_a     (ld_push),
    .push_a_ent (ld_ent),
    .push_b     (alu_push),
    .push_b_ent (alu_ent),
    .pop        (pop),
    .head_ent   (head_ent),
    .count      (count),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );

  // An idle cycle keeps the last address/data on the port; only the enable drops.
  always_comb begin
    out_d = out_q;
    if (flush || !pop) out_d.kind = WEN_IDLE;
    else               out_d      = head_ent;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) out_q <= '0;
    else       out_q <= out_d;
  end

  assign WEn   = out_q.kind;
  assign AddrD = AW'(out_q.addr);
  assign DataD = DW'(out_q.data);

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) busy[ent_addr[i*REG_AW +: REG_AW]] = 1'b1;
    end
    if (out_q.kind != WEN_IDLE) busy[out_q.addr] = 1'b1;
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed vector table, reset-mid-drain sequence and a
// randomized run against a queue-based reference model.
module tb_rf_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        flush;
  logic        alu_valid, ld_valid;
  logic        alu_ready, ld_ready;
  logic [3:0]  alu_addr, ld_addr;
  logic [31:0] alu_data, ld_data;
  logic [1:0]  alu_kind;
  logic [1:0]  WEn;
  logic [3:0]  AddrD;
  logic [31:0] DataD;
  logic [15:0] busy;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_wb_ctrl #(.DEPTH(4), .AW(4), .DW(32)) dut (
    .clk(clk), .rst_(rst_), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
    .alu_data(alu_data), .alu_kind(alu_kind),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .WEn(WEn), .AddrD(AddrD), .DataD(DataD), .busy(busy), .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [3:0] la, input logic [31:0] ldd,
                       input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic [1:0] ak, input logic fl);
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    alu_valid = av; alu_addr = aa; alu_data = ad; alu_kind = ak;
    flush = fl;
  endtask

  // Directed vectors: inputs held for one cycle, outputs expected mid-cycle.
  typedef struct {
    logic        lv; logic [3:0] la; logic [31:0] ldd;
    logic        av; logic [3:0] aa; logic [31:0] ad; logic [1:0] ak;
    logic        fl;
    logic        e_ldr; logic e_alur; logic [2:0] e_cnt; logic [1:0] e_wen;
    logic [3:0]  e_addr; logic [31:0] e_data; logic [15:0] e_busy;
  } vec_t;

  vec_t tbl [24];

  // Reference model: plain FIFO of pending writes plus the issued write.
  typedef struct { logic [1:0] k; logic [3:0] a; logic [31:0] d; } ent_t;
  ent_t mq[$];
  ent_t mo;

  function automatic logic [15:0] model_busy();
    logic [15:0] b = '0;
    foreach (mq[i]) b[mq[i].a] = 1'b1;
    if (mo.k != 2'b00) b[mo.a] = 1'b1;
    return b;
  endfunction

  task automatic model_check(input string tag);
    logic ldr, alur;
    ldr  = !flush && (mq.size() < 4);
    alur = !flush && ((mq.size() < 3) || (mq.size() < 4 && !ld_valid));
    chk({tag, " ld_ready"}, ld_ready, ldr);
    chk({tag, " alu_ready"}, alu_ready, alur);
    chk({tag, " count"}, count, mq.size());
    chk({tag, " WEn"}, WEn, mo.k);
    chk({tag, " AddrD"}, AddrD, mo.a);
    chk({tag, " DataD"}, DataD, mo.d);
    chk({tag, " busy"}, busy, model_busy());
  endtask

  task automatic model_step();
    int   n;
    logic ldr, alur;
    ent_t e;
    n    = mq.size();
    ldr  = !flush && (n < 4);
    alur = !flush && ((n < 3) || (n < 4 && !ld_valid));
    if (flush) begin
      mq.delete();
      mo.k = 2'b00;
    end else begin
      if (n > 0) mo = mq.pop_front();
      else       mo.k = 2'b00;
      if (ld_valid && ldr) begin
        e.k = 2'b11; e.a = ld_addr; e.d = ld_data;
        mq.push_back(e);
      end
      if (alu_valid && alur && alu_kind != 2'b00) begin
        e.k = alu_kind; e.a = alu_addr; e.d = (alu_kind == 2'b11) ? alu_data : 32'h0;
        mq.push_back(e);
      end
    end
  endtask

  initial begin
    tbl[0]  = '{0,0,0,          1,5,32'hAB,3,     0, 1,1,0,0,5'h0,32'h0,16'h0000};
    tbl[1]  = '{0,0,0,          0,0,0,0,          0, 1,1,1,0,0,0,16'h0020};
    tbl[2]  = '{0,0,0,          0,0,0,0,          0, 1,1,0,3,5,32'hAB,16'h0020};
    tbl[3]  = '{0,0,0,          0,0,0,0,          0, 1,1,0,0,5,32'hAB,16'h0000};
    tbl[4]  = '{1,3,32'h11111111, 1,4,32'hDEAD,1, 0, 1,1,0,0,5,32'hAB,16'h0000};
    tbl[5]  = '{0,0,0,          0,0,0,0,          0, 1,1,2,0,5,32'hAB,16'h0018};
    tbl[6]  = '{0,0,0,          0,0,0,0,          0, 1,1,1,3,3,32'h11111111,16'h0018};
    tbl[7]  = '{0,0,0,          0,0,0,0,          0, 1,1,0,1,4,32'h0,16'h0010};
    tbl[8]  = '{0,0,0,          1,9,32'h1234,0,   0, 1,1,0,0,4,32'h0,16'h0000};
    tbl[9]  = '{0,0,0,          0,0,0,0,          0, 1,1,0,0,4,32'h0,16'h0000};
    tbl[10] = '{1,1,32'h10,     1,2,32'h20,3,     0, 1,1,0,0,4,32'h0,16'h0000};
    tbl[11] = '{1,3,32'h30,     1,4,32'h40,3,     0, 1,1,2,0,4,32'h0,16'h0006};
    tbl[12] = '{1,5,32'h50,     1,6,32'h60,3,     0, 1,0,3,3,1,32'h10,16'h001E};
    tbl[13] = '{0,0,0,          0,0,0,0,          0, 1,1,3,3,2,32'h20,16'h003C};
    tbl[14] = '{1,8,32'h88,     0,0,0,0,          1, 0,0,2,3,3,32'h30,16'h0038};
    tbl[15] = '{0,0,0,          0,0,0,0,          0, 1,1,0,0,3,32'h30,16'h0000};
    tbl[16] = '{0,0,0,          1,7,32'h77,3,     0, 1,1,0,0,3,32'h30,16'h0000};
    tbl[17] = '{0,0,0,          1,7,32'h55,2,     0, 1,1,1,0,3,32'h30,16'h0080};
    tbl[18] = '{0,0,0,          0,0,0,0,          0, 1,1,1,3,7,32'h77,16'h0080};
    tbl[19] = '{0,0,0,          0,0,0,0,          0, 1,1,0,2,7,32'h0,16'h0080};
    tbl[20] = '{0,0,0,          0,0,0,0,          0, 1,1,0,0,7,32'h0,16'h0000};
    tbl[21] = '{1,0,32'hCAFE,   0,0,0,0,          0, 1,1,0,0,7,32'h0,16'h0000};
    tbl[22] = '{0,0,0,          0,0,0,0,          0, 1,1,1,0,7,32'h0,16'h0001};
    tbl[23] = '{0,0,0,          0,0,0,0,          0, 1,1,0,3,0,32'hCAFE,16'h0001};

    rst_ = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst WEn", WEn, 2'b00);
    chk("rst count", count, 0);
    #4 rst_ = 1'b1;
    #1;
    chk("rst AddrD", AddrD, 0);
    chk("rst DataD", DataD, 0);
    chk("rst busy", busy, 0);
    chk("rst ld_ready", ld_ready, 1);
    chk("rst alu_ready", alu_ready, 1);

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].lv, tbl[i].la, tbl[i].ldd, tbl[i].av, tbl[i].aa,
            tbl[i].ad, tbl[i].ak, tbl[i].fl);
      #4;
      chk($sformatf("vec%0d ld_ready", i), ld_ready, tbl[i].e_ldr);
      chk($sformatf("vec%0d alu_ready", i), alu_ready, tbl[i].e_alur);
      chk($sformatf("vec%0d count", i), count, tbl[i].e_cnt);
      chk($sformatf("vec%0d WEn", i), WEn, tbl[i].e_wen);
      chk($sformatf("vec%0d AddrD", i), AddrD, tbl[i].e_addr);
      chk($sformatf("vec%0d DataD", i), DataD, tbl[i].e_data);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
    end

    // Reset dropped while a write is on the port and another is queued.
    @(posedge clk); #1;
    drive(1, 9, 32'h99, 1, 10, 32'hAA, 3, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("drain WEn before rst", WEn, 2'b11);
    #1 rst_ = 1'b0;
    #1;
    chk("async rst WEn", WEn, 2'b00);
    chk("async rst count", count, 0);
    chk("async rst busy", busy, 0);
    chk("async rst AddrD", AddrD, 0);
    #2 rst_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #5;
      chk($sformatf("post-rst%0d WEn", i), WEn, 2'b00);
      chk($sformatf("post-rst%0d count", i), count, 0);
    end

    // Randomized run against the reference model.
    mq.delete();
    mo = '{k: 2'b00, a: 4'h0, d: 32'h0};
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom,
            $urandom_range(0, 3) != 0, 4'($urandom), $urandom,
            2'($urandom), $urandom_range(0, 40) == 0);
      #4;
      model_check($sformatf("rnd%0d", c));
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
